// File: rtl/tlb_search_arb.sv
// Shares the single TLB search port among TLBP, data and inst lookups; unmapped
// kseg0/kseg1 accesses bypass the port and are answered from the address alone.
module tlb_search_arb #(
    parameter logic [31:0] UNMAP_MASK = 32'h1fff_ffff
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        inst_req,
    input  logic [31:0] inst_vaddr,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_paddr,
    output logic        inst_found,
    output logic        inst_v,
    output logic        inst_d,
    input  logic        data_req,
    input  logic [31:0] data_vaddr,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_paddr,
    output logic        data_found,
    output logic        data_v,
    output logic        data_d,
    input  logic        tlbp_req,
    output logic        tlbp_addr_ok,
    output logic [5:0]  tlbp_bus,
    input  logic [26:0] entryhi_bus,
    input  logic        tlb_we,
    input  logic        cancel,
    output logic [18:0] s_vpn2,
    output logic        s_odd,
    output logic [7:0]  s_asid,
    input  logic        s_found,
    input  logic [3:0]  s_index,
    input  logic [19:0] s_pfn,
    input  logic [2:0]  s_c,
    input  logic        s_d,
    input  logic        s_v
);

    typedef enum logic {RR_DATA = 1'b0, RR_INST = 1'b1} rr_t;

    rr_t  rr;
    logic inst_unmap, data_unmap;
    logic inst_map, data_map;
    logic map_block;
    logic grant_tlbp, grant_data, grant_inst;
    logic unused;

    assign unused = ^s_c;

    always_comb begin
        inst_unmap = (inst_vaddr[31:30] == 2'b10);
        data_unmap = (data_vaddr[31:30] == 2'b10);
        inst_map   = inst_req & ~inst_unmap;
        data_map   = data_req & ~data_unmap;
        map_block  = ~resetn | cancel | tlb_we;
        grant_tlbp = tlbp_req & ~map_block;
        grant_data = 1'b0;
        grant_inst = 1'b0;
        // tlbp owns the port outright; otherwise rr breaks a data/inst tie
        if (!map_block && !tlbp_req) begin
            if (data_map && (!inst_map || rr == RR_DATA))
                grant_data = 1'b1;
            else if (inst_map)
                grant_inst = 1'b1;
        end
    end

    always_comb begin
        inst_addr_ok = resetn & ~cancel & inst_req & (inst_unmap | grant_inst);
        data_addr_ok = resetn & ~cancel & data_req & (data_unmap | grant_data);
        tlbp_addr_ok = grant_tlbp;
    end

    always_comb begin
        s_asid = entryhi_bus[7:0];
        s_vpn2 = '0;
        s_odd  = 1'b0;
        if (grant_tlbp) begin
            s_vpn2 = entryhi_bus[26:8];
        end else if (grant_data) begin
            s_vpn2 = data_vaddr[31:13];
            s_odd  = data_vaddr[12];
        end else if (grant_inst) begin
            s_vpn2 = inst_vaddr[31:13];
            s_odd  = inst_vaddr[12];
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            rr           <= RR_DATA;
            inst_data_ok <= 1'b0;
            inst_paddr   <= '0;
            inst_found   <= 1'b0;
            inst_v       <= 1'b0;
            inst_d       <= 1'b0;
            data_data_ok <= 1'b0;
            data_paddr   <= '0;
            data_found   <= 1'b0;
            data_v       <= 1'b0;
            data_d       <= 1'b0;
            tlbp_bus     <= '0;
        end else begin
            inst_data_ok <= inst_addr_ok;
            data_data_ok <= data_addr_ok;
            tlbp_bus[5]  <= grant_tlbp;
            if (grant_tlbp)
                tlbp_bus[4:0] <= {s_found, s_index};
            if (grant_data)
                rr <= RR_INST;
            else if (grant_inst)
                rr <= RR_DATA;
            if (inst_addr_ok) begin
                if (inst_unmap) begin
                    inst_paddr <= inst_vaddr & UNMAP_MASK;
                    inst_found <= 1'b1;
                    inst_v     <= 1'b1;
                    inst_d     <= 1'b1;
                end else begin
                    inst_paddr <= {s_pfn, inst_vaddr[11:0]};
                    inst_found <= s_found;
                    inst_v     <= s_v;
                    inst_d     <= s_d;
                end
            end
            if (data_addr_ok) begin
                if (data_unmap) begin
                    data_paddr <= data_vaddr & UNMAP_MASK;
                    data_found <= 1'b1;
                    data_v     <= 1'b1;
                    data_d     <= 1'b1;
                end else begin
                    data_paddr <= {s_pfn, data_vaddr[11:0]};
                    data_found <= s_found;
                    data_v     <= s_v;
                    data_d     <= s_d;
                end
            end
        end
    end

endmodule

// File: tb/tb_tlb_search_arb.sv
// Bench for tlb_search_arb: a 16-entry TLB model answers the search port, and a
// priority-list reference model predicts grants and responses.
module tb_tlb_search_arb;

    typedef struct packed {
        logic [18:0] vpn2;
        logic [7:0]  asid;
        logic        g;
        logic [19:0] pfn0;
        logic [19:0] pfn1;
        logic        v0, v1, d0, d1;
    } ent_t;

    typedef struct packed {
        logic        found;
        logic [3:0]  idx;
        logic [19:0] pfn;
        logic        v;
        logic        d;
    } hit_t;

    logic        clk, resetn;
    logic        inst_req, data_req, tlbp_req, tlb_we, cancel;
    logic [31:0] inst_vaddr, data_vaddr;
    logic [26:0] entryhi_bus;
    logic        inst_addr_ok, inst_data_ok, inst_found, inst_v, inst_d;
    logic        data_addr_ok, data_data_ok, data_found, data_v, data_d;
    logic [31:0] inst_paddr, data_paddr;
    logic        tlbp_addr_ok;
    logic [5:0]  tlbp_bus;
    logic [18:0] s_vpn2;
    logic        s_odd, s_found, s_d, s_v;
    logic [7:0]  s_asid;
    logic [3:0]  s_index;
    logic [19:0] s_pfn;
    logic [2:0]  s_c;

    ent_t tlb [16];
    ent_t we_ent;
    logic [3:0] we_idx;
    hit_t env_hit;

    int checks = 0;
    int failures = 0;

    // reference model state
    logic        m_rr;
    int unsigned m_win;
    logic        g_i, g_d, g_t;
    logic [18:0] e_svpn2;
    logic        e_sodd;
    logic        e_iok, e_dok, e_tvalid;
    logic [31:0] e_ip, e_dp;
    logic [2:0]  e_if, e_df;
    logic [4:0]  e_tbus;

    tlb_search_arb #(.UNMAP_MASK(32'h1fff_ffff)) dut (
        .clk(clk), .resetn(resetn),
        .inst_req(inst_req), .inst_vaddr(inst_vaddr), .inst_addr_ok(inst_addr_ok),
        .inst_data_ok(inst_data_ok), .inst_paddr(inst_paddr), .inst_found(inst_found),
        .inst_v(inst_v), .inst_d(inst_d),
        .data_req(data_req), .data_vaddr(data_vaddr), .data_addr_ok(data_addr_ok),
        .data_data_ok(data_data_ok), .data_paddr(data_paddr), .data_found(data_found),
        .data_v(data_v), .data_d(data_d),
        .tlbp_req(tlbp_req), .tlbp_addr_ok(tlbp_addr_ok), .tlbp_bus(tlbp_bus),
        .entryhi_bus(entryhi_bus), .tlb_we(tlb_we), .cancel(cancel),
        .s_vpn2(s_vpn2), .s_odd(s_odd), .s_asid(s_asid),
        .s_found(s_found), .s_index(s_index), .s_pfn(s_pfn), .s_c(s_c),
        .s_d(s_d), .s_v(s_v)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // lowest matching index wins
    function automatic hit_t tlb_find(input logic [18:0] vpn2, input logic odd, input logic [7:0] asid);
        hit_t h;
        h = '0;
        for (int i = 15; i >= 0; i--) begin
            if (tlb[i].vpn2 == vpn2 && (tlb[i].g || tlb[i].asid == asid)) begin
                h.found = 1'b1;
                h.idx   = 4'(i);
                h.pfn   = odd ? tlb[i].pfn1 : tlb[i].pfn0;
                h.v     = odd ? tlb[i].v1 : tlb[i].v0;
                h.d     = odd ? tlb[i].d1 : tlb[i].d0;
            end
        end
        return h;
    endfunction

    always_comb env_hit = tlb_find(s_vpn2, s_odd, s_asid);
    assign s_found = env_hit.found;
    assign s_index = env_hit.idx;
    assign s_pfn   = env_hit.pfn;
    assign s_v     = env_hit.v;
    assign s_d     = env_hit.d;
    assign s_c     = 3'd3;

    // {paddr, found, v, d} the requester should receive for this address
    function automatic logic [34:0] expect_resp(input logic [31:0] va);
        hit_t h;
        if (va[31:30] == 2'b10)
            return {va & 32'h1fff_ffff, 3'b111};
        h = tlb_find(va[31:13], va[12], entryhi_bus[7:0]);
        return {h.pfn, va[11:0], h.found, h.v, h.d};
    endfunction

    task automatic model_comb();
        int unsigned order [3];
        logic [2:0] want;
        logic im, dm;
        im = inst_req && inst_vaddr[31:30] != 2'b10;
        dm = data_req && data_vaddr[31:30] != 2'b10;
        want = {im, dm, tlbp_req};
        if (m_rr) order = '{0, 2, 1};
        else      order = '{0, 1, 2};
        m_win = 3;
        if (resetn && !cancel && !tlb_we)
            foreach (order[k]) if (m_win == 3 && want[order[k]]) m_win = order[k];
        g_t = (m_win == 0);
        g_d = resetn && !cancel && data_req && (!dm || m_win == 1);
        g_i = resetn && !cancel && inst_req && (!im || m_win == 2);
        e_svpn2 = '0;
        e_sodd  = 1'b0;
        case (m_win)
            0: e_svpn2 = entryhi_bus[26:8];
            1: {e_svpn2, e_sodd} = data_vaddr[31:12];
            2: {e_svpn2, e_sodd} = inst_vaddr[31:12];
            default: ;
        endcase
    endtask

    task automatic model_clock();
        hit_t h;
        if (!resetn) begin
            m_rr = 1'b0; e_iok = 1'b0; e_dok = 1'b0; e_tvalid = 1'b0;
        end else begin
            e_iok = g_i; e_dok = g_d; e_tvalid = g_t;
            if (g_i) {e_ip, e_if} = expect_resp(inst_vaddr);
            if (g_d) {e_dp, e_df} = expect_resp(data_vaddr);
            if (g_t) begin
                h = tlb_find(entryhi_bus[26:8], 1'b0, entryhi_bus[7:0]);
                e_tbus = {h.found, h.idx};
            end
            if (m_win == 1) m_rr = 1'b1;
            else if (m_win == 2) m_rr = 1'b0;
        end
    endtask

    task automatic settle();
        #1;
        model_comb();
    endtask

    // TLB write lands on the same edge the arbiter samples
    task automatic advance();
        model_clock();
        @(posedge clk);
        #1;
        if (tlb_we) tlb[we_idx] = we_ent;
        @(negedge clk);
    endtask

    task automatic init_tlb();
        for (int i = 0; i < 16; i++) begin
            tlb[i] = '0;
            tlb[i].vpn2 = 19'h7ff00 + 19'(i);
        end
    endtask

    task automatic set_ent(input int idx, input logic [18:0] vpn2, input logic [19:0] pfn0);
        tlb[idx] = '0;
        tlb[idx].vpn2 = vpn2;
        tlb[idx].g    = 1'b1;
        tlb[idx].pfn0 = pfn0;
        tlb[idx].v0   = 1'b1;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        inst_req = 1'b1; inst_vaddr = 32'h8000_0000;
        data_req = 1'b1; data_vaddr = 32'h0000_4000;
        settle();
        checks++;
        if (inst_addr_ok !== 1'b0 || data_addr_ok !== 1'b0 || tlbp_addr_ok !== 1'b0) begin
            failures++;
            $display("FAIL reset_addr_ok got=%b%b%b exp=000", inst_addr_ok, data_addr_ok, tlbp_addr_ok);
        end
        advance();
        advance();
        checks++;
        if ({inst_data_ok, data_data_ok, tlbp_bus} !== 8'h00) begin
            failures++;
            $display("FAIL reset_strobes got=%b%b %b exp=00 000000", inst_data_ok, data_data_ok, tlbp_bus);
        end
        checks++;
        if ({inst_paddr, data_paddr, inst_found, inst_v, inst_d, data_found, data_v, data_d} !== '0) begin
            failures++;
            $display("FAIL reset_results got ip=%h dp=%h if=%b%b%b df=%b%b%b exp=0", inst_paddr, data_paddr,
                     inst_found, inst_v, inst_d, data_found, data_v, data_d);
        end
        resetn = 1'b1; inst_req = 1'b0; data_req = 1'b0;
    endtask

    task automatic test_unmapped();
        inst_req = 1'b1; inst_vaddr = 32'hbfc0_0000;
        data_req = 1'b1; data_vaddr = 32'h8000_1234;
        settle();
        checks++;
        if (inst_addr_ok !== 1'b1 || data_addr_ok !== 1'b1) begin
            failures++;
            $display("FAIL unmapped_addr_ok got=%b%b exp=11", inst_addr_ok, data_addr_ok);
        end
        advance();
        inst_req = 1'b0; data_req = 1'b0;
        checks++;
        if (inst_data_ok !== 1'b1 || inst_paddr !== 32'h1fc0_0000 || {inst_found, inst_v, inst_d} !== 3'b111) begin
            failures++;
            $display("FAIL unmapped_inst got ok=%b pa=%h f=%b%b%b exp ok=1 pa=1fc00000 f=111",
                     inst_data_ok, inst_paddr, inst_found, inst_v, inst_d);
        end
        checks++;
        if (data_data_ok !== 1'b1 || data_paddr !== 32'h0000_1234 || {data_found, data_v, data_d} !== 3'b111) begin
            failures++;
            $display("FAIL unmapped_data got ok=%b pa=%h f=%b%b%b exp ok=1 pa=00001234 f=111",
                     data_data_ok, data_paddr, data_found, data_v, data_d);
        end
    endtask

    task automatic test_contention();
        init_tlb();
        set_ent(0, 19'h00010, 20'h00abc);
        entryhi_bus = {19'h0, 8'h11};
        inst_req = 1'b1; inst_vaddr = 32'h0002_0000;
        data_req = 1'b1; data_vaddr = 32'h0002_0000;
        for (int k = 0; k < 3; k++) begin
            settle();
            checks++;
            if (data_addr_ok !== (k != 1) || inst_addr_ok !== (k == 1) || s_vpn2 !== 19'h00010) begin
                failures++;
                $display("FAIL contention_grant k=%0d got d=%b i=%b vpn2=%h exp d=%b i=%b vpn2=00010",
                         k, data_addr_ok, inst_addr_ok, s_vpn2, k != 1, k == 1);
            end
            advance();
            checks++;
            if ((k == 1 ? inst_data_ok : data_data_ok) !== 1'b1 || (k == 1 ? data_data_ok : inst_data_ok) !== 1'b0
                || (k == 1 ? inst_paddr : data_paddr) !== 32'h00ab_c000) begin
                failures++;
                $display("FAIL contention_resp k=%0d got iok=%b dok=%b ip=%h dp=%h exp paddr=00abc000",
                         k, inst_data_ok, data_data_ok, inst_paddr, data_paddr);
            end
        end
        inst_req = 1'b0; data_req = 1'b0;
    endtask

    task automatic test_tlbp_priority();
        set_ent(5, 19'h00005, 20'h00555);
        entryhi_bus = {19'h00005, 8'h11};
        tlbp_req = 1'b1;
        inst_req = 1'b1; inst_vaddr = 32'h0002_0000;
        data_req = 1'b1; data_vaddr = 32'h0002_0000;
        settle();
        checks++;
        if (tlbp_addr_ok !== 1'b1 || data_addr_ok !== 1'b0 || inst_addr_ok !== 1'b0
            || s_vpn2 !== 19'h00005 || s_odd !== 1'b0 || s_asid !== 8'h11) begin
            failures++;
            $display("FAIL tlbp_grant got t=%b d=%b i=%b vpn2=%h odd=%b asid=%h exp t=1 d=0 i=0 vpn2=00005 odd=0 asid=11",
                     tlbp_addr_ok, data_addr_ok, inst_addr_ok, s_vpn2, s_odd, s_asid);
        end
        advance();
        tlbp_req = 1'b0;
        checks++;
        if (tlbp_bus !== 6'b11_0101) begin
            failures++;
            $display("FAIL tlbp_bus got=%b exp=110101", tlbp_bus);
        end
        // rr was left pointing at inst by the contention sequence
        settle();
        checks++;
        if (inst_addr_ok !== 1'b1 || data_addr_ok !== 1'b0) begin
            failures++;
            $display("FAIL tlbp_follow1 got i=%b d=%b exp i=1 d=0", inst_addr_ok, data_addr_ok);
        end
        advance();
        inst_req = 1'b0;
        checks++;
        if (tlbp_bus[5] !== 1'b0 || inst_data_ok !== 1'b1 || inst_paddr !== 32'h00ab_c000) begin
            failures++;
            $display("FAIL tlbp_follow1_resp got tv=%b iok=%b ip=%h exp tv=0 iok=1 ip=00abc000",
                     tlbp_bus[5], inst_data_ok, inst_paddr);
        end
        settle();
        checks++;
        if (data_addr_ok !== 1'b1) begin
            failures++;
            $display("FAIL tlbp_follow2 got d=%b exp d=1", data_addr_ok);
        end
        advance();
        data_req = 1'b0;
    endtask

    task automatic test_write_fence();
        we_idx = 4'd3;
        we_ent = '0;
        we_ent.vpn2 = 19'h00020; we_ent.g = 1'b1; we_ent.pfn0 = 20'h00def;
        we_ent.v0 = 1'b1; we_ent.d0 = 1'b1;
        tlb_we = 1'b1;
        inst_req = 1'b1; inst_vaddr = 32'h0004_0000;
        data_req = 1'b1; data_vaddr = 32'ha000_0010;
        settle();
        checks++;
        if (inst_addr_ok !== 1'b0 || data_addr_ok !== 1'b1) begin
            failures++;
            $display("FAIL fence_grant got i=%b d=%b exp i=0 d=1", inst_addr_ok, data_addr_ok);
        end
        advance();
        tlb_we = 1'b0; data_req = 1'b0;
        checks++;
        if (data_data_ok !== 1'b1 || data_paddr !== 32'h0000_0010) begin
            failures++;
            $display("FAIL fence_unmapped_resp got ok=%b pa=%h exp ok=1 pa=00000010", data_data_ok, data_paddr);
        end
        settle();
        checks++;
        if (inst_addr_ok !== 1'b1) begin
            failures++;
            $display("FAIL fence_retry got i=%b exp i=1", inst_addr_ok);
        end
        advance();
        inst_req = 1'b0;
        checks++;
        if (inst_data_ok !== 1'b1 || inst_paddr !== 32'h00de_f000 || {inst_found, inst_v, inst_d} !== 3'b111) begin
            failures++;
            $display("FAIL fence_new_entry got ok=%b pa=%h f=%b%b%b exp ok=1 pa=00def000 f=111",
                     inst_data_ok, inst_paddr, inst_found, inst_v, inst_d);
        end
    endtask

    task automatic test_cancel();
        data_req = 1'b1; data_vaddr = 32'h0002_0000;
        settle();
        checks++;
        if (data_addr_ok !== 1'b1) begin
            failures++;
            $display("FAIL cancel_setup got d=%b exp d=1", data_addr_ok);
        end
        advance();
        data_req = 1'b0;
        inst_req = 1'b1; inst_vaddr = 32'h8000_0100;
        cancel = 1'b1;
        checks++;
        if (data_data_ok !== 1'b1 || data_paddr !== 32'h00ab_c000) begin
            failures++;
            $display("FAIL cancel_visible got ok=%b pa=%h exp ok=1 pa=00abc000", data_data_ok, data_paddr);
        end
        settle();
        checks++;
        if (inst_addr_ok !== 1'b0) begin
            failures++;
            $display("FAIL cancel_block got i=%b exp i=0", inst_addr_ok);
        end
        advance();
        cancel = 1'b0;
        checks++;
        if (data_data_ok !== 1'b0 || inst_data_ok !== 1'b0) begin
            failures++;
            $display("FAIL cancel_after got dok=%b iok=%b exp 0 0", data_data_ok, inst_data_ok);
        end
        settle();
        advance();
        inst_req = 1'b0;
    endtask

    task automatic test_reset_midop();
        data_req = 1'b1; data_vaddr = 32'h0002_0000;
        settle();
        advance();
        // data just won, so inst would be preferred unless reset clears rr
        resetn = 1'b0;
        inst_req = 1'b1; inst_vaddr = 32'h0002_0000;
        settle();
        checks++;
        if (data_addr_ok !== 1'b0 || inst_addr_ok !== 1'b0) begin
            failures++;
            $display("FAIL midreset_addr_ok got d=%b i=%b exp 0 0", data_addr_ok, inst_addr_ok);
        end
        advance();
        resetn = 1'b1;
        checks++;
        if ({inst_data_ok, data_data_ok, tlbp_bus} !== 8'h00 || inst_paddr !== '0 || data_paddr !== '0
            || {inst_found, inst_v, inst_d, data_found, data_v, data_d} !== '0) begin
            failures++;
            $display("FAIL midreset_outputs got iok=%b dok=%b tb=%b ip=%h dp=%h exp all 0",
                     inst_data_ok, data_data_ok, tlbp_bus, inst_paddr, data_paddr);
        end
        settle();
        checks++;
        if (data_addr_ok !== 1'b1 || inst_addr_ok !== 1'b0) begin
            failures++;
            $display("FAIL midreset_rr got d=%b i=%b exp d=1 i=0", data_addr_ok, inst_addr_ok);
        end
        advance();
        data_req = 1'b0;
        settle();
        advance();
        inst_req = 1'b0;
    endtask

    function automatic logic [31:0] rand_va();
        case ($urandom_range(0, 3))
            0:       return {2'b10, 30'($urandom)};
            1:       return {2'b11, 17'($urandom_range(0, 9)), 13'($urandom)};
            default: return {19'($urandom_range(0, 9)), 13'($urandom)};
        endcase
    endfunction

    task automatic test_random();
        for (int i = 0; i < 8; i++) begin
            tlb[i] = '0;
            tlb[i].vpn2 = 19'(i);
            tlb[i].asid = 8'h11;
            tlb[i].g    = i[0];
            tlb[i].pfn0 = 20'h00100 + 20'(i);
            tlb[i].pfn1 = 20'h00200 + 20'(i);
            tlb[i].v0 = 1'b1; tlb[i].v1 = i[1]; tlb[i].d0 = i[2]; tlb[i].d1 = 1'b1;
        end
        for (int c = 0; c < 600; c++) begin
            if (!inst_req || g_i) begin
                inst_req = $urandom_range(0, 3) != 0;
                inst_vaddr = rand_va();
            end
            if (!data_req || g_d) begin
                data_req = $urandom_range(0, 3) != 0;
                data_vaddr = rand_va();
            end
            if (!tlbp_req || g_t) tlbp_req = $urandom_range(0, 4) == 0;
            entryhi_bus = {19'($urandom_range(0, 9)), ($urandom_range(0, 1) != 0) ? 8'h11 : 8'h22};
            cancel = $urandom_range(0, 15) == 0;
            resetn = $urandom_range(0, 63) != 0;
            tlb_we = $urandom_range(0, 11) == 0;
            we_idx = 4'($urandom_range(0, 15));
            we_ent = '0;
            we_ent.vpn2 = 19'($urandom_range(0, 9));
            we_ent.asid = ($urandom_range(0, 1) != 0) ? 8'h11 : 8'h22;
            we_ent.g = 1'($urandom); we_ent.pfn0 = 20'($urandom); we_ent.pfn1 = 20'($urandom);
            {we_ent.v0, we_ent.v1, we_ent.d0, we_ent.d1} = 4'($urandom);
            settle();
            checks++;
            if ({inst_addr_ok, data_addr_ok, tlbp_addr_ok} !== {g_i, g_d, g_t}) begin
                failures++;
                $display("FAIL rand_grant cyc=%0d got i=%b d=%b t=%b exp i=%b d=%b t=%b",
                         c, inst_addr_ok, data_addr_ok, tlbp_addr_ok, g_i, g_d, g_t);
            end
            checks++;
            if (s_vpn2 !== e_svpn2 || s_odd !== e_sodd || s_asid !== entryhi_bus[7:0]) begin
                failures++;
                $display("FAIL rand_port cyc=%0d got vpn2=%h odd=%b asid=%h exp vpn2=%h odd=%b asid=%h",
                         c, s_vpn2, s_odd, s_asid, e_svpn2, e_sodd, entryhi_bus[7:0]);
            end
            advance();
            checks++;
            if (inst_data_ok !== e_iok || data_data_ok !== e_dok || tlbp_bus[5] !== e_tvalid) begin
                failures++;
                $display("FAIL rand_strobe cyc=%0d got iok=%b dok=%b tv=%b exp iok=%b dok=%b tv=%b",
                         c, inst_data_ok, data_data_ok, tlbp_bus[5], e_iok, e_dok, e_tvalid);
            end
            if (e_iok) begin
                checks++;
                if ({inst_paddr, inst_found, inst_v, inst_d} !== {e_ip, e_if}) begin
                    failures++;
                    $display("FAIL rand_inst_resp cyc=%0d got pa=%h f=%b%b%b exp pa=%h f=%b",
                             c, inst_paddr, inst_found, inst_v, inst_d, e_ip, e_if);
                end
            end
            if (e_dok) begin
                checks++;
                if ({data_paddr, data_found, data_v, data_d} !== {e_dp, e_df}) begin
                    failures++;
                    $display("FAIL rand_data_resp cyc=%0d got pa=%h f=%b%b%b exp pa=%h f=%b",
                             c, data_paddr, data_found, data_v, data_d, e_dp, e_df);
                end
            end
            if (e_tvalid) begin
                checks++;
                if (tlbp_bus[4:0] !== e_tbus) begin
                    failures++;
                    $display("FAIL rand_tlbp_resp cyc=%0d got=%b exp=%b", c, tlbp_bus[4:0], e_tbus);
                end
            end
        end
        inst_req = 1'b0; data_req = 1'b0; tlbp_req = 1'b0;
        cancel = 1'b0; tlb_we = 1'b0; resetn = 1'b1;
    endtask

    initial begin
        resetn = 1'b0; inst_req = 1'b0; data_req = 1'b0; tlbp_req = 1'b0;
        inst_vaddr = '0; data_vaddr = '0; entryhi_bus = '0;
        tlb_we = 1'b0; cancel = 1'b0; we_idx = '0; we_ent = '0;
        m_rr = 1'b0; m_win = 3; g_i = 1'b0; g_d = 1'b0; g_t = 1'b0;
        e_iok = 1'b0; e_dok = 1'b0; e_tvalid = 1'b0;
        e_ip = '0; e_dp = '0; e_if = '0; e_df = '0; e_tbus = '0;
        e_svpn2 = '0; e_sodd = 1'b0;
        init_tlb();
        @(negedge clk);
        test_reset();
        test_unmapped();
        test_contention();
        test_tlbp_priority();
        test_write_fence();
        test_cancel();
        test_reset_midop();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
